// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter byte port among NUM_REQ requesters.
// The grant is held for a whole packet; an optional channel-ID header byte precedes each packet.
module uart_tx_arbiter #(
   parameter int                    NUM_REQ     = 4,
   parameter int                    DATA_WIDTH  = 8,
   parameter bit                    HEADER_EN   = 1'b1,
   parameter logic [DATA_WIDTH-1:0] HEADER_BASE = 8'hA0,
   parameter int                    MAX_PKT_LEN = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [DATA_WIDTH-1:0]         tx_data,
   output logic                          tx_valid,
   input  logic                          tx_ready,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          busy,
   output logic                          pkt_done,
   output logic                          pkt_trunc
);

   localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_HEADER  = 2'd1;
   localparam logic [1:0] ST_PAYLOAD = 2'd2;

   logic [1:0]            state;
   logic [ID_W-1:0]       grant_id;
   logic [ID_W-1:0]       last_id;
   logic [CNT_W-1:0]      byte_cnt;
   logic [DATA_WIDTH-1:0] hdr_byte;

   logic                  sel_found;
   logic [ID_W-1:0]       sel_id;
   int                    rr_cand;

   logic                  g_valid;
   logic                  g_last;
   logic [DATA_WIDTH-1:0] g_data;
   logic                  payload_xfer;
   logic                  hit_max;

   // Round-robin search starting just after the previous owner
   always_comb begin
      sel_found = 1'b0;
      sel_id    = '0;
      rr_cand   = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         rr_cand = (int'(last_id) + k) % NUM_REQ;
         if (!sel_found && req_valid[rr_cand]) begin
            sel_found = 1'b1;
            sel_id    = ID_W'(rr_cand);
         end
      end
   end

   assign g_valid      = req_valid[grant_id];
   assign g_last       = req_last[grant_id];
   assign g_data       = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
   assign payload_xfer = (state == ST_PAYLOAD) && g_valid && tx_ready;
   assign hit_max      = (byte_cnt == CNT_W'(MAX_PKT_LEN - 1));
   assign busy         = (state != ST_IDLE);

   // Payload is a combinational pass-through so the owner sees the transmitter's ready directly
   always_comb begin
      tx_valid  = 1'b0;
      tx_data   = '0;
      req_ready = '0;
      case (state)
         ST_HEADER: begin
            tx_valid = 1'b1;
            tx_data  = hdr_byte;
         end
         ST_PAYLOAD: begin
            tx_valid  = g_valid;
            tx_data   = g_data;
            req_ready = grant & {NUM_REQ{tx_ready}};
         end
         default: begin
            tx_valid  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state     <= ST_IDLE;
         grant     <= '0;
         grant_id  <= '0;
         last_id   <= ID_W'(NUM_REQ - 1);
         byte_cnt  <= '0;
         hdr_byte  <= '0;
         pkt_done  <= 1'b0;
         pkt_trunc <= 1'b0;
      end else begin
         pkt_done  <= 1'b0;
         pkt_trunc <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (sel_found) begin
                  grant_id <= sel_id;
                  grant    <= NUM_REQ'(1) << sel_id;
                  hdr_byte <= HEADER_BASE | DATA_WIDTH'(sel_id);
                  byte_cnt <= '0;
                  state    <= HEADER_EN ? ST_HEADER : ST_PAYLOAD;
               end
            end
            ST_HEADER: begin
               if (tx_ready) begin
                  state <= ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               // A last byte that also hits the length limit counts as a normal end
               if (payload_xfer) begin
                  if (g_last || hit_max) begin
                     state     <= ST_IDLE;
                     grant     <= '0;
                     last_id   <= grant_id;
                     byte_cnt  <= '0;
                     pkt_done  <= g_last;
                     pkt_trunc <= !g_last;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               grant <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: per-requester byte queues drive the DUT while a
// packet-level model predicts grants, the transmitter byte stream and end-of-packet pulses.
module tb_uart_tx_arbiter;

   localparam int         NUM_REQ = 4;
   localparam int         DW      = 8;
   localparam int         MAX_LEN = 16;
   localparam logic [7:0] HDR     = 8'hA0;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NUM_REQ*DW-1:0] req_data;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_last;
   logic [NUM_REQ-1:0]    req_ready;
   logic [DW-1:0]         tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic [NUM_REQ-1:0]    grant;
   logic                  busy;
   logic                  pkt_done;
   logic                  pkt_trunc;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .DATA_WIDTH (DW),
      .HEADER_EN  (1'b1),
      .HEADER_BASE(HDR),
      .MAX_PKT_LEN(MAX_LEN)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_data (req_data),
      .req_valid(req_valid),
      .req_last (req_last),
      .req_ready(req_ready),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .grant    (grant),
      .busy     (busy),
      .pkt_done (pkt_done),
      .pkt_trunc(pkt_trunc)
   );

   // Requester streams: bit 8 is the last flag, bits 7:0 the byte
   logic [8:0] rq [NUM_REQ][$];
   bit         pop_pend [NUM_REQ];

   int         m_owner;
   int         m_last_id;
   bit         m_hdr;
   bit         m_trunc;
   bit         m_pd;
   bit         m_pt;
   bit         m_known;
   logic [7:0] m_exp[$];

   logic [7:0] tx_log[$];
   int         n_done;
   int         n_trunc;
   int         n_checks;
   int         n_fail;
   int         cyc;
   bit         rand_mode;
   int         ready_pat;

   task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // The model sees a packet as header + bytes up to the first last flag, capped at MAX_LEN
   task automatic buildPacket(input int g);
      int n;
      m_owner = g;
      m_hdr   = 1'b1;
      m_trunc = 1'b1;
      m_exp.delete();
      m_exp.push_back(HDR | 8'(g));
      n = 0;
      for (int j = 0; j < rq[g].size() && n < MAX_LEN; j++) begin
         m_exp.push_back(rq[g][j][7:0]);
         n++;
         if (rq[g][j][8]) begin
            m_trunc = 1'b0;
            break;
         end
      end
   endtask

   task automatic applyStimulus(input bit do_reset);
      @(negedge clk);
      cyc++;
      rst_n = do_reset;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pop_pend[i]) begin
            void'(rq[i].pop_front());
            req_valid[i] = 1'b0;
            pop_pend[i]  = 1'b0;
         end
         if (!req_valid[i] && rq[i].size() > 0 && (!rand_mode || $urandom_range(99) < 50))
            req_valid[i] = 1'b1;
         if (req_valid[i]) begin
            req_data[i*DW +: DW] = rq[i][0][7:0];
            req_last[i]          = rq[i][0][8];
         end else begin
            req_data[i*DW +: DW] = 8'($urandom);
            req_last[i]          = 1'($urandom);
         end
      end
      if (do_reset)            tx_ready = 1'b0;
      else if (ready_pat == 0) tx_ready = 1'b1;
      else if (ready_pat == 1) tx_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      else                     tx_ready = 1'($urandom_range(1));
   endtask

   task automatic checkOutput(input bit do_reset);
      int g;
      #1;
      if (m_known) begin
         compareValue("busy", busy, m_owner >= 0);
         compareValue("grant", grant, (m_owner >= 0) ? (1 << m_owner) : 0);
         compareValue("pkt_done", pkt_done, m_pd);
         compareValue("pkt_trunc", pkt_trunc, m_pt);
         if (m_owner < 0) begin
            compareValue("idle_tx_valid", tx_valid, 0);
            compareValue("idle_req_ready", req_ready, 0);
         end else if (m_hdr) begin
            compareValue("hdr_tx_valid", tx_valid, 1);
            compareValue("hdr_tx_data", tx_data, m_exp[0]);
            compareValue("hdr_req_ready", req_ready, 0);
         end else begin
            compareValue("pl_tx_valid", tx_valid, req_valid[m_owner]);
            if (req_valid[m_owner]) compareValue("pl_tx_data", tx_data, m_exp[0]);
            compareValue("pl_req_ready", req_ready, tx_ready ? (1 << m_owner) : 0);
         end
      end

      if (!do_reset && tx_valid === 1'b1 && tx_ready) tx_log.push_back(tx_data);
      if (pkt_done === 1'b1)  n_done++;
      if (pkt_trunc === 1'b1) n_trunc++;
      for (int i = 0; i < NUM_REQ; i++)
         if (!do_reset && req_valid[i] && req_ready[i] === 1'b1) pop_pend[i] = 1'b1;

      m_pd = 1'b0;
      m_pt = 1'b0;
      if (do_reset) begin
         m_known   = 1'b1;
         m_owner   = -1;
         m_hdr     = 1'b0;
         m_last_id = NUM_REQ - 1;
         m_exp.delete();
      end else if (m_known) begin
         if (m_owner < 0) begin
            if (req_valid != '0) begin
               g = -1;
               for (int k = 1; k <= NUM_REQ; k++)
                  if (g < 0 && req_valid[(m_last_id + k) % NUM_REQ]) g = (m_last_id + k) % NUM_REQ;
               buildPacket(g);
            end
         end else if (m_hdr) begin
            if (tx_ready) begin
               void'(m_exp.pop_front());
               m_hdr = 1'b0;
            end
         end else if (req_valid[m_owner] && tx_ready) begin
            void'(m_exp.pop_front());
            if (m_exp.size() == 0) begin
               m_pd      = !m_trunc;
               m_pt      = m_trunc;
               m_last_id = m_owner;
               m_owner   = -1;
            end
         end
      end
   endtask

   task automatic step();
      applyStimulus(1'b0);
      checkOutput(1'b0);
   endtask

   task automatic doReset();
      applyStimulus(1'b1);
      checkOutput(1'b1);
   endtask

   task automatic clearObs();
      tx_log.delete();
      n_done  = 0;
      n_trunc = 0;
   endtask

   function automatic bit allIdle();
      bit r;
      r = (m_owner < 0);
      for (int i = 0; i < NUM_REQ; i++)
         if (rq[i].size() > 0 || pop_pend[i]) r = 1'b0;
      return r;
   endfunction

   task automatic runUntilIdle(input string tag, input int budget);
      int c;
      c = 0;
      while (c < budget && !allIdle()) begin
         step();
         c++;
      end
      compareValue({tag, "_drained"}, allIdle(), 1);
      step();
      step();
   endtask

   task automatic checkLog(input string name, input logic [7:0] e[$]);
      compareValue({name, "_len"}, tx_log.size(), e.size());
      for (int j = 0; j < e.size() && j < tx_log.size(); j++)
         compareValue($sformatf("%s_byte%0d", name, j), tx_log[j], e[j]);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: time limit reached, cycle %0d", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] e[$];
      int len, r;
      n_checks  = 0;
      n_fail    = 0;
      cyc       = 0;
      m_known   = 1'b0;
      m_owner   = -1;
      rand_mode = 1'b0;
      ready_pat = 0;
      rst_n     = 1'b0;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      tx_ready  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) pop_pend[i] = 1'b0;

      $display("[TB] single packet");
      doReset();
      step();
      compareValue("reset_grant", grant, 0);
      compareValue("reset_busy", busy, 0);
      compareValue("reset_tx_valid", tx_valid, 0);
      clearObs();
      rq[0].push_back(9'h011);
      rq[0].push_back(9'h122);
      runUntilIdle("single", 50);
      e = {8'hA0, 8'h11, 8'h22};
      checkLog("single", e);
      compareValue("single_done", n_done, 1);
      compareValue("single_trunc", n_trunc, 0);
      compareValue("single_grant_end", grant, 0);

      $display("[TB] round robin");
      doReset();
      clearObs();
      for (int i = 0; i < NUM_REQ; i++) rq[i].push_back(9'h130 + 9'(i));
      runUntilIdle("rr4", 100);
      e = {8'hA0, 8'h30, 8'hA1, 8'h31, 8'hA2, 8'h32, 8'hA3, 8'h33};
      checkLog("rr4", e);
      compareValue("rr4_done", n_done, 4);
      clearObs();
      rq[0].push_back(9'h140);
      rq[0].push_back(9'h141);
      rq[2].push_back(9'h150);
      rq[2].push_back(9'h151);
      runUntilIdle("rr2", 100);
      e = {8'hA0, 8'h40, 8'hA2, 8'h50, 8'hA0, 8'h41, 8'hA2, 8'h51};
      checkLog("rr2", e);

      $display("[TB] grant lock");
      doReset();
      clearObs();
      rq[1].push_back(9'h061);
      rq[1].push_back(9'h062);
      rq[1].push_back(9'h163);
      step();
      step();
      step();
      rq[0].push_back(9'h170);
      runUntilIdle("lock", 100);
      e = {8'hA1, 8'h61, 8'h62, 8'h63, 8'hA0, 8'h70};
      checkLog("lock", e);

      $display("[TB] backpressure");
      doReset();
      clearObs();
      ready_pat = 1;
      rq[3].push_back(9'h081);
      rq[3].push_back(9'h082);
      rq[3].push_back(9'h083);
      rq[3].push_back(9'h184);
      runUntilIdle("bp", 100);
      ready_pat = 0;
      e = {8'hA3, 8'h81, 8'h82, 8'h83, 8'h84};
      checkLog("bp", e);
      compareValue("bp_done", n_done, 1);

      $display("[TB] truncation");
      doReset();
      clearObs();
      for (int j = 0; j < 20; j++) rq[2].push_back({j == 19, 8'(j)});
      runUntilIdle("trunc20", 200);
      e = {8'hA2};
      for (int j = 0; j < 16; j++) e.push_back(8'(j));
      e.push_back(8'hA2);
      for (int j = 16; j < 20; j++) e.push_back(8'(j));
      checkLog("trunc20", e);
      compareValue("trunc20_trunc", n_trunc, 1);
      compareValue("trunc20_done", n_done, 1);
      clearObs();
      for (int j = 0; j < 16; j++) rq[2].push_back({j == 15, 8'(8'h20 + j)});
      runUntilIdle("exact16", 200);
      compareValue("exact16_len", tx_log.size(), 17);
      compareValue("exact16_done", n_done, 1);
      compareValue("exact16_trunc", n_trunc, 0);

      $display("[TB] reset mid-packet");
      doReset();
      clearObs();
      for (int j = 0; j < 6; j++) rq[1].push_back({j == 5, 8'(8'h91 + j)});
      for (int c = 0; c < 20 && tx_log.size() < 3; c++) step();
      compareValue("midrst_progress", tx_log.size(), 3);
      doReset();
      clearObs();
      rq[0].push_back(9'h1A5);
      step();
      compareValue("midrst_grant", grant, 0);
      compareValue("midrst_busy", busy, 0);
      compareValue("midrst_tx_valid", tx_valid, 0);
      compareValue("midrst_pulses", n_done + n_trunc, 0);
      runUntilIdle("midrst", 100);
      e = {8'hA0, 8'hA5, 8'hA1, 8'h93, 8'h94, 8'h95, 8'h96};
      checkLog("midrst", e);

      $display("[TB] randomized traffic");
      doReset();
      clearObs();
      rand_mode = 1'b1;
      ready_pat = 2;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(99) < 4) begin
            r   = $urandom_range(NUM_REQ - 1);
            len = $urandom_range(24, 1);
            if (rq[r].size() < 60)
               for (int j = 0; j < len; j++) rq[r].push_back({j == len - 1, 8'($urandom)});
         end
         step();
      end
      runUntilIdle("random", 20000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
